uart_bus_master: RTL and testbench

UART_BUS_MASTER -- requirements
Module: uart_bus_master

---
 rtl/uart_bus_master.sv | 204 ++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART command bridge: decodes 4-byte write / 3-byte read frames from a byte
// stream, performs one memory bus access and returns an ACK or the read data.
module uart_bus_master #(
    parameter int         TIMEOUT  = 2500000,
    parameter logic [7:0] ACK_BYTE = 8'h4B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_got,
    input  logic [7:0]  rx_byte,
    input  logic        rx_error,
    output logic [7:0]  tx_byte,
    output logic        transmit,
    input  logic        is_transmitting,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] addr,
    output logic        we,
    output logic [7:0]  data_out,
    input  logic [7:0]  data_in,
    output logic        busy
);

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam int         CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR_H   = 4'd1,
        ADDR_L   = 4'd2,
        DATA     = 4'd3,
        REQ      = 4'd4,
        WRITE    = 4'd5,
        RD_WAIT  = 4'd6,
        RD_CAP   = 4'd7,
        TX_START = 4'd8,
        TX_WAIT  = 4'd9
    } state_t;

    state_t        state_q, state_d;
    logic          cmd_wr_q, cmd_wr_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          we_q, we_d;
    logic          transmit_q, transmit_d;
    logic          bus_req_q, bus_req_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state and next-output computation for the frame/access sequencer
    always_comb begin
        state_d    = state_q;
        cmd_wr_d   = cmd_wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_byte_d  = tx_byte_q;
        we_d       = 1'b0;
        transmit_d = transmit_q;
        bus_req_d  = bus_req_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_got && ((rx_byte == CMD_WR) || (rx_byte == CMD_RD))) begin
                    cmd_wr_d = (rx_byte == CMD_WR);
                    state_d  = ADDR_H;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR_H: begin
                if (rx_error) begin
                    state_d = IDLE;
                end else if (rx_got) begin
                    addr_d[15:8] = rx_byte;
                    cnt_d        = '0;
                    state_d      = ADDR_L;
                end else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ADDR_L: begin
                if (rx_error) begin
                    state_d = IDLE;
                end else if (rx_got) begin
                    addr_d[7:0] = rx_byte;
                    cnt_d       = '0;
                    if (cmd_wr_q) begin
                        state_d = DATA;
                    end else begin
                        state_d   = REQ;
                        bus_req_d = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (rx_error) begin
                    state_d = IDLE;
                end else if (rx_got) begin
                    data_d    = rx_byte;
                    cnt_d     = '0;
                    state_d   = REQ;
                    bus_req_d = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REQ: begin
                bus_req_d = 1'b1;
                if (bus_gnt) begin
                    we_d    = cmd_wr_q;
                    state_d = cmd_wr_q ? WRITE : RD_WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WRITE: begin
                tx_byte_d = ACK_BYTE;
                bus_req_d = 1'b0;
                state_d   = TX_START;
            end
            RD_WAIT: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                tx_byte_d = data_in;
                bus_req_d = 1'b0;
                state_d   = TX_START;
            end
            TX_START: begin
                // transmit rises only with the uart idle and falls once it reports busy
                if (!transmit_q) begin
                    transmit_d = !is_transmitting;
                end else if (is_transmitting) begin
                    transmit_d = 1'b0;
                    state_d    = TX_WAIT;
                end else begin
                    transmit_d = 1'b1;
                end
            end
            TX_WAIT: begin
                if (!is_transmitting) begin
                    state_d = IDLE;
                end else begin
                    state_d = TX_WAIT;
                end
            end
            default: begin
                state_d    = IDLE;
                bus_req_d  = 1'b0;
                transmit_d = 1'b0;
                cnt_d      = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Sequencer state and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_wr_q   <= 1'b0;
            addr_q     <= 16'h0000;
            data_q     <= 8'h00;
            tx_byte_q  <= 8'h00;
            we_q       <= 1'b0;
            transmit_q <= 1'b0;
            bus_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_wr_q   <= cmd_wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_byte_q  <= tx_byte_d;
            we_q       <= we_d;
            transmit_q <= transmit_d;
            bus_req_q  <= bus_req_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_byte  = tx_byte_q;
    assign transmit = transmit_q;
    assign bus_req  = bus_req_q;
    assign addr     = addr_q;
    assign we       = we_q;
    assign data_out = data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a simple uart responder and a
// registered-read memory model.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_got = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_error = 1'b0;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic        is_transmitting;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data_out;
    logic [7:0]  data_in = 8'h00;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic        clr = 1'b0;
    logic        uart_mute = 1'b0;
    logic        uart_busy = 1'b0;
    int          tx_timer = 0;
    int          tx_cnt = 0;
    logic [7:0]  last_tx = 8'h00;
    int          we_cnt = 0;
    logic [15:0] we_addr = 16'h0000;
    logic [7:0]  we_data = 8'h00;
    logic        breq_seen = 1'b0;
    int          lat;
    int          hi_cnt;

    uart_bus_master #(.TIMEOUT(100), .ACK_BYTE(8'h4B)) dut (
        .clk(clk), .rst_n(rst_n), .rx_got(rx_got), .rx_byte(rx_byte),
        .rx_error(rx_error), .tx_byte(tx_byte), .transmit(transmit),
        .is_transmitting(is_transmitting), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .addr(addr), .we(we), .data_out(data_out), .data_in(data_in), .busy(busy)
    );

    always #5 clk = ~clk;
    assign is_transmitting = uart_busy;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return (a == 16'hFFFF) ? 8'h3C : (a[7:0] ^ 8'hA5);
    endfunction

    always @(posedge clk) data_in <= mem_f(addr);

    // uart responder: accepts a byte when idle, stays busy for a few cycles
    always @(posedge clk) begin
        if (!uart_busy) begin
            if (transmit && !uart_mute) begin
                uart_busy <= 1'b1;
                tx_timer  <= 4;
                tx_cnt    <= tx_cnt + 1;
                last_tx   <= tx_byte;
            end
        end else if (tx_timer == 0) begin
            uart_busy <= 1'b0;
        end else begin
            tx_timer <= tx_timer - 1;
        end
        if (we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= addr;
            we_data <= data_out;
        end
        if (bus_req) breq_seen <= 1'b1;
        if (clr) begin
            tx_cnt    <= 0;
            we_cnt    <= 0;
            breq_seen <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_got = 1'b1; rx_byte = b;
        @(negedge clk); rx_got = 1'b0; rx_byte = 8'h00;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_breq(input string tag);
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_req) break;
        end
        check(tag, {31'd0, bus_req}, 32'd1);
    endtask

    initial begin
        #1;
        check("rst_addr", {16'd0, addr}, 32'd0);
        check("rst_outs", {24'd0, busy, bus_req, we, transmit, 4'd0}, 32'd0);
        check("rst_data", {16'd0, data_out, tx_byte}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // write 57 00 10 A5 with grant already high
        bus_gnt = 1'b1;
        clear_stats();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'hA5);
        wait_idle("wr_idle");
        check("wr_we_cnt", we_cnt, 32'd1);
        check("wr_we_addr", {16'd0, we_addr}, 32'h0010);
        check("wr_we_data", {24'd0, we_data}, 32'hA5);
        check("wr_tx_cnt", tx_cnt, 32'd1);
        check("wr_ack", {24'd0, last_tx}, 32'h4B);
        check("wr_breq_off", {31'd0, bus_req}, 32'd0);

        // read 52 FF FF, grant raised in REQ to measure latency
        bus_gnt = 1'b0;
        clear_stats();
        send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFF);
        wait_breq("rd_breq");
        bus_gnt = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            lat++;
            if (transmit) break;
        end
        check("rd_latency", lat, 32'd3);
        wait_idle("rd_idle");
        check("rd_we_cnt", we_cnt, 32'd0);
        check("rd_addr", {16'd0, addr}, 32'hFFFF);
        check("rd_tx_cnt", tx_cnt, 32'd1);
        check("rd_data", {24'd0, last_tx}, 32'h3C);

        // write with grant held off for 10 cycles
        bus_gnt = 1'b0;
        clear_stats();
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'h5C);
        wait_breq("hold_breq");
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_req) hi_cnt++;
            @(negedge clk);
        end
        check("hold_breq_cycles", hi_cnt, 32'd10);
        check("hold_no_we", we_cnt, 32'd0);
        bus_gnt = 1'b1;
        wait_idle("hold_idle");
        check("hold_we_cnt", we_cnt, 32'd1);
        check("hold_we_addr", {16'd0, we_addr}, 32'h1234);
        check("hold_we_data", {24'd0, we_data}, 32'h5C);
        check("hold_ack", {24'd0, last_tx}, 32'h4B);
        check("hold_tx_cnt", tx_cnt, 32'd1);

        // inter-byte timeout after 57 12
        clear_stats();
        send_byte(8'h57); send_byte(8'h12);
        repeat (50) @(negedge clk);
        check("to_still_busy", {31'd0, busy}, 32'd1);
        repeat (60) @(negedge clk);
        check("to_idle", {31'd0, busy}, 32'd0);
        check("to_no_breq", {31'd0, breq_seen}, 32'd0);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
        wait_idle("to_rd_idle");
        check("to_rd_tx_cnt", tx_cnt, 32'd1);
        check("to_rd_data", {24'd0, last_tx}, 32'hA4);

        // unknown command and framing error
        clear_stats();
        send_byte(8'h41);
        check("bad_cmd_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h57); send_byte(8'h00);
        check("err_pre_busy", {31'd0, busy}, 32'd1);
        @(negedge clk); rx_error = 1'b1;
        @(negedge clk); rx_error = 1'b0;
        check("err_idle", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("err_no_we", we_cnt, 32'd0);
        check("err_no_tx", tx_cnt, 32'd0);
        check("err_no_breq", {31'd0, breq_seen}, 32'd0);

        // asynchronous reset while a read response waits in TX_START
        uart_mute = 1'b1;
        clear_stats();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h02);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (transmit) break;
        end
        check("ar_tx_up", {31'd0, transmit}, 32'd1);
        check("ar_busy_up", {31'd0, busy}, 32'd1);
        check("ar_tx_byte", {24'd0, tx_byte}, 32'hA7);
        #1 rst_n = 1'b0;
        #1;
        check("ar_tx_down", {31'd0, transmit}, 32'd0);
        check("ar_busy_down", {31'd0, busy}, 32'd0);
        check("ar_addr", {16'd0, addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        uart_mute = 1'b0;
        repeat (20) @(negedge clk);
        check("ar_no_tx", tx_cnt, 32'd0);
        check("ar_no_we", we_cnt, 32'd0);
        check("ar_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
